// File: rtl/lza_if.sv
// Handshake and data bundle between the alignment stage, the LZA and the normaliser.
interface lza_if #(
    parameter int M           = 23,
    parameter int SHIFT_WIDTH = $clog2(M + 3)
);
    localparam int W = M + 2;

    logic                   in_valid;
    logic                   in_ready;
    logic [W-1:0]           A;
    logic [W-1:0]           B;
    logic                   out_valid;
    logic                   out_ready;
    logic [SHIFT_WIDTH-1:0] shift_amt;
    logic                   lza_carry;
    logic                   zero;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, shift_amt, lza_carry, zero
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, shift_amt, lza_carry, zero
    );
endinterface

// File: rtl/lza_pipelined.sv
// Two-stage leading-zero anticipator: stage 1 encodes E = A^B per group,
// stage 2 selects the top non-empty group and forms shift/carry/zero.
module lza_pipelined #(
    parameter int M           = 23,
    parameter int GROUP_SIZE  = 5,
    parameter int SHIFT_WIDTH = $clog2(M + 3)
) (
    input  logic clk,
    input  logic rst,
    lza_if.slave io
);
    localparam int W          = M + 2;
    localparam int NUM_GROUPS = (W + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int PW         = NUM_GROUPS * GROUP_SIZE;
    localparam int LW         = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
    localparam int IW         = $clog2(W);

    logic                           adv;
    logic [PW-1:0]                  e_pad;
    logic [NUM_GROUPS-1:0]          grp_or_d;
    logic [NUM_GROUPS-1:0][LW-1:0]  grp_loc_d;

    logic                           s1_valid;
    logic [NUM_GROUPS-1:0]          s1_or;
    logic [NUM_GROUPS-1:0][LW-1:0]  s1_loc;
    logic [W-1:0]                   s1_z;

    logic                           hit;
    logic [IW-1:0]                  idx;
    logic                           carry_d;
    logic [SHIFT_WIDTH-1:0]         shift_d;

    logic                           s2_valid;
    logic [SHIFT_WIDTH-1:0]         s2_shift;
    logic                           s2_carry;
    logic                           s2_zero;

    assign adv         = ~s2_valid | io.out_ready;
    assign io.in_ready = adv;

    // Top group is zero-padded so every group has the same shape.
    always_comb begin
        e_pad        = '0;
        e_pad[W-1:0] = io.A ^ io.B;
    end

    // Local index counts from the group MSB; the last hit in an upward scan is the highest bit.
    always_comb begin
        grp_or_d  = '0;
        grp_loc_d = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            grp_or_d[g] = |e_pad[g*GROUP_SIZE +: GROUP_SIZE];
            for (int j = 0; j < GROUP_SIZE; j++) begin
                if (e_pad[g*GROUP_SIZE + j])
                    grp_loc_d[g] = LW'(GROUP_SIZE - 1 - j);
            end
        end
    end

    // Modular arithmetic at IW bits is exact because the winning bit always lies below W.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (s1_or[g]) begin
                hit = 1'b1;
                idx = IW'(g*GROUP_SIZE + GROUP_SIZE - 1) - IW'(s1_loc[g]);
            end
        end
        carry_d = 1'b0;
        if (hit && (idx != '0))
            carry_d = s1_z[idx - 1'b1];
        shift_d = '0;
        if (hit)
            shift_d = SHIFT_WIDTH'(M + 1) - SHIFT_WIDTH'(idx) + SHIFT_WIDTH'(carry_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_or    <= '0;
            s1_loc   <= '0;
            s1_z     <= '0;
            s2_valid <= 1'b0;
            s2_shift <= '0;
            s2_carry <= 1'b0;
            s2_zero  <= 1'b0;
        end else if (adv) begin
            s1_valid <= io.in_valid;
            s1_or    <= grp_or_d;
            s1_loc   <= grp_loc_d;
            s1_z     <= ~io.A & io.B;
            s2_valid <= s1_valid;
            s2_shift <= shift_d;
            s2_carry <= carry_d;
            s2_zero  <= ~hit;
        end
    end

    assign io.out_valid = s2_valid;
    assign io.shift_amt = s2_shift;
    assign io.lza_carry = s2_carry;
    assign io.zero      = s2_zero;
endmodule

// File: tb/tb_lza_pipelined.sv
// Directed and random checks of lza_pipelined, run in lock-step on five group sizes.
module tb_lza_pipelined;
    localparam int M  = 23;
    localparam int W  = M + 2;
    localparam int SW = $clog2(M + 3);
    localparam int ND = 5;

    function automatic int gs_of(int k);
        case (k)
            0: return 5;
            1: return 1;
            2: return 4;
            3: return 7;
            default: return 25;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a, b;

    logic [ND-1:0]         ov, lc, zf, ir;
    logic [ND-1:0][SW-1:0] sa;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < ND; k++) begin : g_dut
        lza_if #(.M(M), .SHIFT_WIDTH(SW)) io ();
        assign io.in_valid  = in_valid;
        assign io.A         = a;
        assign io.B         = b;
        assign io.out_ready = out_ready;
        lza_pipelined #(.M(M), .GROUP_SIZE(gs_of(k)), .SHIFT_WIDTH(SW)) u_dut (
            .clk (clk),
            .rst (rst),
            .io  (io)
        );
        assign ov[k] = io.out_valid;
        assign sa[k] = io.shift_amt;
        assign lc[k] = io.lza_carry;
        assign zf[k] = io.zero;
        assign ir[k] = io.in_ready;
    end

    // Reference: scan E from the top down, one bit at a time.
    function automatic logic [SW+1:0] ref_lza(logic [W-1:0] x, logic [W-1:0] y);
        logic [W-1:0] e, z;
        int idx;
        logic c;
        e = x ^ y;
        z = ~x & y;
        idx = -1;
        for (int i = W - 1; i >= 0; i--)
            if (e[i] && idx < 0) idx = i;
        if (idx < 0) return {SW'(0), 1'b0, 1'b1};
        c = (idx > 0) ? z[idx-1] : 1'b0;
        return {SW'(M + 1 - idx + int'(c)), c, 1'b0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic ev, logic [SW-1:0] es, logic ec, logic ez, logic data);
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            if (data) begin
                assert ({ov[k], sa[k], lc[k], zf[k]} === {ev, es, ec, ez}) else begin
                    n_err++;
                    $error("FAIL %s gs=%0d: got v=%b s=%0d c=%b z=%b, expected v=%b s=%0d c=%b z=%b",
                           tag, gs_of(k), ov[k], sa[k], lc[k], zf[k], ev, es, ec, ez);
                end
            end else begin
                assert (ov[k] === ev) else begin
                    n_err++;
                    $error("FAIL %s gs=%0d: got out_valid=%b, expected %b", tag, gs_of(k), ov[k], ev);
                end
            end
        end
    endtask

    task automatic chk_t(string tag, logic [SW+1:0] t);
        chk(tag, 1'b1, t[SW+1:2], t[1], t[0], 1'b1);
    endtask

    task automatic chk_rdy(string tag, logic exp);
        for (int k = 0; k < ND; k++) begin
            n_vec++;
            assert (ir[k] === exp) else begin
                n_err++;
                $error("FAIL %s gs=%0d: got in_ready=%b, expected %b", tag, gs_of(k), ir[k], exp);
            end
        end
    endtask

    task automatic apply1(string tag, logic [W-1:0] x, logic [W-1:0] y,
                          logic [SW-1:0] es, logic ec, logic ez);
        a = x; b = y; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick;
        chk(tag, 1'b1, es, ec, ez, 1'b1);
    endtask

    logic [SW+1:0] exp_q[$];
    logic [W-1:0]  pa[3], pb[3];
    logic [SW+1:0] pe[3];

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        tick; tick;
        rst = 1'b0;
        chk("reset", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk_rdy("reset_rdy", 1'b1);

        // Hand-computed directed vectors.
        apply1("top_bit",     25'h1000000, 25'h0000000, 5'd0,  1'b0, 1'b0);
        apply1("carry_fix",   25'h0C00000, 25'h0A00000, 5'd3,  1'b1, 1'b0);
        apply1("bit0",        25'h0000001, 25'h0000000, 5'd24, 1'b0, 1'b0);
        apply1("bit0_b",      25'h0000000, 25'h0000001, 5'd24, 1'b0, 1'b0);
        apply1("equal",       25'h0ABCDEF, 25'h0ABCDEF, 5'd0,  1'b0, 1'b1);
        apply1("top_carry",   25'h0000000, 25'h1800000, 5'd1,  1'b1, 1'b0);
        apply1("mid_nocarry", 25'h0000100, 25'h0000000, 5'd16, 1'b0, 1'b0);

        // Back-to-back random stream, one pair per cycle.
        for (int i = 0; i <= 10000; i++) begin
            if (i < 10000) begin
                a = W'({$urandom, $urandom});
                case ($urandom_range(3))
                    0: b = W'({$urandom, $urandom});
                    1: b = a ^ (W'({$urandom, $urandom}) >> $urandom_range(W - 1));
                    2: b = a;
                    default: b = a + W'($urandom_range(3)) - W'(1);
                endcase
                in_valid = 1'b1;
                exp_q.push_back(ref_lza(a, b));
            end else begin
                in_valid = 1'b0;
            end
            tick;
            if (i >= 1) chk_t("stream", exp_q.pop_front());
        end
        tick;
        chk("stream_drain", 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Back-pressure: three pairs offered while the consumer stalls.
        pa[0] = 25'h0C00000; pb[0] = 25'h0A00000;
        pa[1] = 25'h1234567; pb[1] = 25'h1234567;
        pa[2] = 25'h0000040; pb[2] = 25'h0000020;
        for (int i = 0; i < 3; i++) pe[i] = ref_lza(pa[i], pb[i]);
        out_ready = 1'b0;
        a = pa[0]; b = pb[0]; in_valid = 1'b1;
        tick;
        chk_rdy("bp_fill1_rdy", 1'b1);
        a = pa[1]; b = pb[1];
        tick;
        chk_rdy("bp_fill2_rdy", 1'b0);
        a = pa[2]; b = pb[2];
        for (int i = 0; i < 4; i++) begin
            chk_t("bp_hold", pe[0]);
            chk_rdy("bp_hold_rdy", 1'b0);
            tick;
        end
        chk_t("bp_hold_end", pe[0]);
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        chk_t("bp_rel1", pe[1]);
        tick;
        chk_t("bp_rel2", pe[2]);
        tick;
        chk("bp_empty", 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Reset with two results in flight.
        a = 25'h1000000; b = '0; in_valid = 1'b1;
        tick;
        a = 25'h0000001;
        tick;
        chk_t("pre_rst", {5'd0, 1'b0, 1'b0});
        in_valid = 1'b0; rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_mid", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk_rdy("rst_mid_rdy", 1'b1);
        tick;
        chk("rst_after1", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick;
        chk("rst_after2", 1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lza_pipelined.md
Name: lza_pipelined

Overview:
- Parametrised, pipelined leading-zero anticipator for the HUB floating-point adder datapath.
- Takes aligned mantissas A and B (M+2 bits each) and produces the normalisation shift amount, a one-bit carry-correction flag and an all-equal (zero-result) flag.
- Two register stages with a valid/ready handshake, so it sits between the alignment stage and the normaliser of a pipelined adder.
- Generalises the combinational LZA:
  - GROUP_SIZE is arbitrary, with the top group zero-padded.
  - The shift width covers every result.
  - Equal operands are flagged explicitly.

Parameters:
- M, 23: mantissa fraction width; operand width W = M+2.
- GROUP_SIZE, 5: bits per priority-encode group, 1..W; need not divide W.
- NUM_GROUPS, ceil(W/GROUP_SIZE): derived, not overridden.
- SHIFT_WIDTH, $clog2(M+3): width of shift_amt; holds 0..M+2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  A/B valid.
- in_ready  out  1  block accepts A/B this cycle.
- A  in  W  operand A mantissa.
- B  in  W  operand B mantissa.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- shift_amt  out  SHIFT_WIDTH  normalisation left-shift amount.
- lza_carry  out  1  correction bit included in shift_amt.
- zero  out  1  A == B (no effective bit).

Behaviour:
- Function, per accepted pair:
  - E = A ^ B; Z = ~A & B.
  - If E == 0: zero=1, shift_amt=0, lza_carry=0.
  - Else:
    - idx = position of the highest set bit of E.
    - lza_carry = (idx > 0) & Z[idx-1].
    - shift_amt = M+1 - idx + lza_carry, computed at SHIFT_WIDTH bits, no truncation.
    - zero=0.
- Stage 1 (register s1):
  - Split E into NUM_GROUPS groups; group g covers bits [g*GROUP_SIZE +: GROUP_SIZE].
  - Bits above W-1 in the top group read as 0.
  - Register per group: the group OR, and the local index of the highest set bit, MSB-first.
  - Also register Z and s1_valid.
- Stage 2 (register s2):
  - Priority-select the highest non-empty group.
  - idx = g*GROUP_SIZE + (GROUP_SIZE-1 - local).
  - Compute lza_carry, shift_amt and zero; register them with s2_valid.
  - out_valid = s2_valid; outputs drive directly from s2 registers.
- Latency: exactly 2 cycles from the accept edge to out_valid when there is no back-pressure. Throughput is 1 result per cycle.
- Handshake:
  - adv = ~s2_valid | out_ready, and in_ready = adv.
  - Input is accepted on in_valid & in_ready.
  - When adv=1, both stages shift together: s1 <= input (valid = in_valid), s2 <= s1.
  - When adv=0, all stage registers hold; outputs stay stable while out_valid & ~out_ready.
  - Bubbles (s1_valid=0) propagate as out_valid=0. Data in invalid slots is don't-care, but must not be X on outputs after reset.
- Reset:
  - s1_valid=0, s2_valid=0, out_valid=0, shift_amt=0, lza_carry=0, zero=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight results; none appears afterwards.
- Boundaries:
  - Idx=W-1 (top bit differs): the top-group path gives shift 0 or 1.
  - Idx=0: lza_carry is forced to 0, never indexing Z[-1]; shift_amt=M+1.
  - A difference only in the padded region cannot occur.
  - A single-group configuration (GROUP_SIZE=W) and GROUP_SIZE=1 both must work.

Test Plan:
- M=23: A=25'h1000000, B=0 -> out_valid 2 cycles later, shift_amt=0, lza_carry=0, zero=0.
- A=25'h0C00000, B=25'h0A00000 -> idx=22, Z[21]=1, lza_carry=1, shift_amt=3. Also A=25'h0000001, B=0 -> shift_amt=24, lza_carry=0.
- A=B=25'h0ABCDEF -> zero=1, shift_amt=0. Then back-to-back random pairs on consecutive cycles -> in-order results, one per cycle, all matching the reference model.
- Fill pipeline with 3 inputs, hold out_ready=0 for 4 cycles:
  - in_ready=0 from the cycle after s2 fills;
  - outputs stable;
  - release -> all 3 results delivered in order, no loss or duplication.
- Assert rst for 1 cycle with 2 results in flight -> out_valid=0 next cycle, no stale results emerge, in_ready=1.
- Re-run the random sweep (10k pairs vs model) at GROUP_SIZE = 1, 4, 5, 7 and 25, covering a non-dividing, padded top group -> bit-exact match.
